// File: rtl/clock_pkg.sv
// clock_pkg: shared types and constants for the clock set/alarm controller.
//   state_t  - controller state encoding (also driven out as `mode`)
//   time_t   - 6-bit hour/minute/second field
//   HOURS, MINS - field moduli
//   wrap_inc - modular increment of a time field
package clock_pkg;

  localparam int unsigned FIELD_W = 6;
  localparam int unsigned HOURS   = 24;
  localparam int unsigned MINS    = 60;

  typedef logic [FIELD_W-1:0] time_t;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_SET_H = 3'd1,
    ST_SET_M = 3'd2,
    ST_SET_S = 3'd3,
    ST_AL_H  = 3'd4,
    ST_AL_M  = 3'd5
  } state_t;

  // Increment v modulo `modulus`; values at or above modulus-1 wrap to 0.
  function automatic time_t wrap_inc(input time_t v, input time_t modulus);
    return (v >= modulus - time_t'(1)) ? '0 : v + time_t'(1);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// btn_edge: registers a debounced button level and flags its rising edge.
//   clk, rst - system clock, async active-high reset
//   btn      - debounced button level
//   rise_c   - combinational rising-edge flag (btn & ~previous btn)
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise_c
);

  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= btn;
  end

  assign rise_c = btn & ~prev_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven time/alarm setting FSM with edit timeout and
// alarm ring control.
//   clk, rst, tick_1s          - clock, async active-high reset, 1 s pulse
//   btn_mode, btn_inc, btn_ok  - debounced button levels
//   cur_h, cur_m, cur_s        - running time from the time-keeper
//   run_en                     - time-keeper count enable (0 while setting time)
//   load, load_h/m/s           - one-cycle commit pulse and values to load
//   edit_h/m/s                 - field values being edited
//   alarm_h/m, alarm_en        - stored alarm and arm flag
//   ring                       - alarm ringing
//   mode                       - current state encoding
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_S    = 30,
  parameter int unsigned RING_S       = 60,
  parameter int unsigned ALARM_H_INIT = 6,
  parameter int unsigned ALARM_M_INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_ok,
  input  logic [5:0] cur_h,
  input  logic [5:0] cur_m,
  input  logic [5:0] cur_s,
  output logic       run_en,
  output logic       load,
  output logic [5:0] load_h,
  output logic [5:0] load_m,
  output logic [5:0] load_s,
  output logic [5:0] edit_h,
  output logic [5:0] edit_m,
  output logic [5:0] edit_s,
  output logic [5:0] alarm_h,
  output logic [5:0] alarm_m,
  output logic       alarm_en,
  output logic       ring,
  output logic [2:0] mode
);

  localparam int unsigned TO_W   = $clog2(TIMEOUT_S + 1);
  localparam int unsigned RING_W = $clog2(RING_S + 1);

  // Button edge detection
  logic mode_rise, inc_rise, ok_rise;

  btn_edge u_edge_mode (.clk(clk), .rst(rst), .btn(btn_mode), .rise_c(mode_rise));
  btn_edge u_edge_inc  (.clk(clk), .rst(rst), .btn(btn_inc),  .rise_c(inc_rise));
  btn_edge u_edge_ok   (.clk(clk), .rst(rst), .btn(btn_ok),   .rise_c(ok_rise));

  // Priority ok > mode > inc; lower-priority edges in the same cycle are dropped
  logic ok_e, mode_e, inc_e, any_e;
  assign ok_e   = ok_rise;
  assign mode_e = mode_rise & ~ok_rise;
  assign inc_e  = inc_rise & ~ok_rise & ~mode_rise;
  assign any_e  = ok_rise | mode_rise | inc_rise;

  state_t            state_q, state_n;
  logic              run_en_q, run_en_n;
  logic              load_q, load_n;
  time_t             load_h_q, load_h_n, load_m_q, load_m_n, load_s_q, load_s_n;
  time_t             edit_h_q, edit_h_n, edit_m_q, edit_m_n, edit_s_q, edit_s_n;
  time_t             alarm_h_q, alarm_h_n, alarm_m_q, alarm_m_n;
  logic              alarm_en_q, alarm_en_n;
  logic              ring_q, ring_n;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_n;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_n;

  logic alarm_hit;
  assign alarm_hit = tick_1s && (cur_h == alarm_h_q) && (cur_m == alarm_m_q) &&
                     (cur_s == time_t'(0));

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      run_en_q   <= 1'b1;
      load_q     <= 1'b0;
      load_h_q   <= '0;
      load_m_q   <= '0;
      load_s_q   <= '0;
      edit_h_q   <= '0;
      edit_m_q   <= '0;
      edit_s_q   <= '0;
      alarm_h_q  <= time_t'(ALARM_H_INIT);
      alarm_m_q  <= time_t'(ALARM_M_INIT);
      alarm_en_q <= 1'b0;
      ring_q     <= 1'b0;
      to_cnt_q   <= '0;
      ring_cnt_q <= '0;
    end else begin
      state_q    <= state_n;
      run_en_q   <= run_en_n;
      load_q     <= load_n;
      load_h_q   <= load_h_n;
      load_m_q   <= load_m_n;
      load_s_q   <= load_s_n;
      edit_h_q   <= edit_h_n;
      edit_m_q   <= edit_m_n;
      edit_s_q   <= edit_s_n;
      alarm_h_q  <= alarm_h_n;
      alarm_m_q  <= alarm_m_n;
      alarm_en_q <= alarm_en_n;
      ring_q     <= ring_n;
      to_cnt_q   <= to_cnt_n;
      ring_cnt_q <= ring_cnt_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state_q;
    load_n     = 1'b0;
    load_h_n   = load_h_q;
    load_m_n   = load_m_q;
    load_s_n   = load_s_q;
    edit_h_n   = edit_h_q;
    edit_m_n   = edit_m_q;
    edit_s_n   = edit_s_q;
    alarm_h_n  = alarm_h_q;
    alarm_m_n  = alarm_m_q;
    alarm_en_n = alarm_en_q;
    ring_n     = ring_q;
    to_cnt_n   = to_cnt_q;
    ring_cnt_n = ring_cnt_q;

    if (ring_q && any_e) begin
      // A button edge silences the ring and is otherwise consumed
      ring_n     = 1'b0;
      ring_cnt_n = '0;
    end else begin
      if (ring_q && tick_1s) begin
        if (ring_cnt_q == RING_W'(RING_S - 1)) begin
          ring_n     = 1'b0;
          ring_cnt_n = '0;
        end else begin
          ring_cnt_n = ring_cnt_q + RING_W'(1);
        end
      end

      case (state_q)
        ST_RUN: begin
          to_cnt_n = '0;
          if (mode_e) begin
            state_n  = ST_SET_H;
            edit_h_n = cur_h;
            edit_m_n = cur_m;
            edit_s_n = cur_s;
          end else if (inc_e) begin
            alarm_en_n = ~alarm_en_q;
          end else if (!any_e && !ring_q && alarm_en_q && alarm_hit) begin
            ring_n     = 1'b1;
            ring_cnt_n = '0;
          end
        end

        ST_SET_H, ST_SET_M, ST_SET_S, ST_AL_H, ST_AL_M: begin
          if (any_e) to_cnt_n = '0;

          if (ok_e) begin
            state_n = ST_RUN;
            if (state_q == ST_AL_H || state_q == ST_AL_M) begin
              alarm_h_n  = edit_h_q;
              alarm_m_n  = edit_m_q;
              alarm_en_n = 1'b1;
            end else begin
              load_n   = 1'b1;
              load_h_n = edit_h_q;
              load_m_n = edit_m_q;
              load_s_n = edit_s_q;
            end
          end else if (mode_e) begin
            case (state_q)
              ST_SET_H: state_n = ST_SET_M;
              ST_SET_M: state_n = ST_SET_S;
              ST_SET_S: begin
                state_n  = ST_AL_H;
                edit_h_n = alarm_h_q;
                edit_m_n = alarm_m_q;
              end
              ST_AL_H:  state_n = ST_AL_M;
              default:  state_n = ST_RUN;
            endcase
          end else if (inc_e) begin
            case (state_q)
              ST_SET_H, ST_AL_H: edit_h_n = wrap_inc(edit_h_q, time_t'(HOURS));
              ST_SET_M, ST_AL_M: edit_m_n = wrap_inc(edit_m_q, time_t'(MINS));
              default:           edit_s_n = wrap_inc(edit_s_q, time_t'(MINS));
            endcase
          end else if (tick_1s) begin
            // Abandon the edit after TIMEOUT_S idle seconds
            if (to_cnt_q == TO_W'(TIMEOUT_S - 1)) begin
              state_n  = ST_RUN;
              to_cnt_n = '0;
            end else begin
              to_cnt_n = to_cnt_q + TO_W'(1);
            end
          end
        end

        default: begin
          state_n  = ST_RUN;
          to_cnt_n = '0;
        end
      endcase
    end

    run_en_n = !(state_n == ST_SET_H || state_n == ST_SET_M || state_n == ST_SET_S);
  end

  assign mode     = state_q;
  assign run_en   = run_en_q;
  assign load     = load_q;
  assign load_h   = load_h_q;
  assign load_m   = load_m_q;
  assign load_s   = load_s_q;
  assign edit_h   = edit_h_q;
  assign edit_m   = edit_m_q;
  assign edit_s   = edit_s_q;
  assign alarm_h  = alarm_h_q;
  assign alarm_m  = alarm_m_q;
  assign alarm_en = alarm_en_q;
  assign ring     = ring_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed self-checking bench for clock_set_ctrl.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1s = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_ok = 1'b0;
  logic [5:0] cur_h = '0, cur_m = '0, cur_s = '0;
  logic       run_en, load, alarm_en, ring;
  logic [5:0] load_h, load_m, load_s, edit_h, edit_m, edit_s, alarm_h, alarm_m;
  logic [2:0] mode;

  int errors = 0;
  int checks = 0;
  int load_cnt = 0;

  clock_set_ctrl dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_ok(btn_ok),
    .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
    .run_en(run_en), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .edit_h(edit_h), .edit_m(edit_m), .edit_s(edit_s),
    .alarm_h(alarm_h), .alarm_m(alarm_m), .alarm_en(alarm_en),
    .ring(ring), .mode(mode)
  );

  always #5 clk = ~clk;

  // Count every cycle in which load is high
  always @(negedge clk) if (load === 1'b1) load_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; step(); btn_mode = 1'b0; step();
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; step(); btn_inc = 1'b0; step();
  endtask

  task automatic press_ok();
    btn_ok = 1'b1; step(); btn_ok = 1'b0; step();
  endtask

  task automatic tick();
    tick_1s = 1'b1; step(); tick_1s = 1'b0; step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (mode !== 3'd0) begin errors++; $display("FAIL reset_mode got=%0d exp=0", mode); end
    checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL reset_run_en got=%b exp=1", run_en); end
    checks++; if (load !== 1'b0 || ring !== 1'b0 || alarm_en !== 1'b0) begin
      errors++; $display("FAIL reset_flags load=%b ring=%b alarm_en=%b exp=0/0/0", load, ring, alarm_en); end
    checks++; if (alarm_h !== 6'd6 || alarm_m !== 6'd0) begin
      errors++; $display("FAIL reset_alarm got=%0d:%0d exp=6:0", alarm_h, alarm_m); end
    checks++; if ({edit_h, edit_m, edit_s, load_h, load_m, load_s} !== 36'd0) begin
      errors++; $display("FAIL reset_fields edit=%0d:%0d:%0d load=%0d:%0d:%0d exp=0", edit_h, edit_m, edit_s, load_h, load_m, load_s); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_mode_cycle();
    int base;
    base = load_cnt;
    cur_h = 6'd10; cur_m = 6'd5; cur_s = 6'd20;
    press_mode();
    checks++; if (mode !== 3'd1 || run_en !== 1'b0) begin
      errors++; $display("FAIL mode_enter mode=%0d run_en=%b exp=1/0", mode, run_en); end
    checks++; if (edit_h !== 6'd10 || edit_m !== 6'd5 || edit_s !== 6'd20) begin
      errors++; $display("FAIL mode_snapshot got=%0d:%0d:%0d exp=10:5:20", edit_h, edit_m, edit_s); end
    press_mode(); press_mode(); press_mode();
    checks++; if (mode !== 3'd4 || run_en !== 1'b1 || edit_h !== 6'd6 || edit_m !== 6'd0) begin
      errors++; $display("FAIL mode_al_h mode=%0d run_en=%b edit=%0d:%0d exp=4/1 6:0", mode, run_en, edit_h, edit_m); end
    press_mode(); press_mode();
    checks++; if (mode !== 3'd0 || run_en !== 1'b1 || load_cnt != base) begin
      errors++; $display("FAIL mode_wrap mode=%0d run_en=%b loads=%0d exp=0/1/0", mode, run_en, load_cnt - base); end
  endtask

  task automatic test_set_commit();
    int base;
    base = load_cnt;
    cur_h = 6'd23; cur_m = 6'd44; cur_s = 6'd12;
    press_mode();
    press_inc();
    checks++; if (edit_h !== 6'd0) begin errors++; $display("FAIL hour_wrap got=%0d exp=0", edit_h); end
    btn_ok = 1'b1; step();
    checks++; if (load !== 1'b1 || load_h !== 6'd0 || load_m !== 6'd44 || load_s !== 6'd12) begin
      errors++; $display("FAIL commit_load load=%b val=%0d:%0d:%0d exp=1 0:44:12", load, load_h, load_m, load_s); end
    checks++; if (mode !== 3'd0 || run_en !== 1'b1) begin
      errors++; $display("FAIL commit_mode mode=%0d run_en=%b exp=0/1", mode, run_en); end
    btn_ok = 1'b0; step();
    checks++; if (load !== 1'b0 || load_cnt != base + 1) begin
      errors++; $display("FAIL commit_pulse load=%b pulses=%0d exp=0/1", load, load_cnt - base); end
  endtask

  task automatic test_timeout();
    int base;
    base = load_cnt;
    cur_h = 6'd12; cur_m = 6'd59; cur_s = 6'd30;
    press_mode();
    repeat (29) tick();
    // Tick and inc together: the count clears and the tick is not counted
    tick_1s = 1'b1; btn_inc = 1'b1; step(); tick_1s = 1'b0; btn_inc = 1'b0; step();
    tick();
    checks++; if (mode !== 3'd1 || edit_h !== 6'd13) begin
      errors++; $display("FAIL timeout_clear mode=%0d edit_h=%0d exp=1/13", mode, edit_h); end
    press_mode();
    press_inc();
    checks++; if (mode !== 3'd2 || edit_m !== 6'd0) begin
      errors++; $display("FAIL min_wrap mode=%0d edit_m=%0d exp=2/0", mode, edit_m); end
    repeat (29) tick();
    checks++; if (mode !== 3'd2) begin errors++; $display("FAIL timeout_early mode=%0d exp=2", mode); end
    tick_1s = 1'b1; step(); tick_1s = 1'b0;
    checks++; if (mode !== 3'd0 || run_en !== 1'b1 || load_cnt != base) begin
      errors++; $display("FAIL timeout_exit mode=%0d run_en=%b loads=%0d exp=0/1/0", mode, run_en, load_cnt - base); end
    step();
  endtask

  task automatic test_alarm_ring();
    int cyc;
    cur_h = 6'd3; cur_m = 6'd3; cur_s = 6'd3;
    repeat (4) press_mode();
    press_inc();
    press_mode();
    repeat (15) press_inc();
    checks++; if (mode !== 3'd5 || edit_h !== 6'd7 || edit_m !== 6'd15) begin
      errors++; $display("FAIL alarm_edit mode=%0d edit=%0d:%0d exp=5 7:15", mode, edit_h, edit_m); end
    press_ok();
    checks++; if (alarm_h !== 6'd7 || alarm_m !== 6'd15 || alarm_en !== 1'b1 || mode !== 3'd0) begin
      errors++; $display("FAIL alarm_store alarm=%0d:%0d en=%b mode=%0d exp=7:15 1 0", alarm_h, alarm_m, alarm_en, mode); end
    cur_h = 6'd7; cur_m = 6'd15; cur_s = 6'd0;
    tick();
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL ring_start got=%b exp=1", ring); end
    cur_s = 6'd1;
    repeat (59) tick();
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL ring_hold got=%b exp=1", ring); end
    cyc = 0;
    tick_1s = 1'b1; step(); tick_1s = 1'b0;
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL ring_stop got=%b exp=0", ring); end
    step();
    // Second ring, cancelled by a mode edge that must not change mode
    cur_s = 6'd0;
    tick();
    cur_s = 6'd1;
    while (ring !== 1'b1 && cyc < 4) begin cyc++; step(); end
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL ring_restart got=%b exp=1", ring); end
    press_mode();
    checks++; if (ring !== 1'b0 || mode !== 3'd0) begin
      errors++; $display("FAIL ring_cancel ring=%b mode=%0d exp=0/0", ring, mode); end
    // Ring start coinciding with inc: the toggle wins and no ring
    cur_s = 6'd0;
    tick_1s = 1'b1; btn_inc = 1'b1; step(); tick_1s = 1'b0; btn_inc = 1'b0; step();
    checks++; if (ring !== 1'b0 || alarm_en !== 1'b0) begin
      errors++; $display("FAIL ring_vs_btn ring=%b alarm_en=%b exp=0/0", ring, alarm_en); end
    cur_s = 6'd1;
  endtask

  task automatic test_back_to_back();
    cur_h = 6'd1; cur_m = 6'd2; cur_s = 6'd59;
    repeat (3) press_mode();
    checks++; if (mode !== 3'd3 || edit_s !== 6'd59) begin
      errors++; $display("FAIL b2b_enter mode=%0d edit_s=%0d exp=3/59", mode, edit_s); end
    btn_ok = 1'b1; btn_inc = 1'b1; step();
    checks++; if (load !== 1'b1 || load_h !== 6'd1 || load_m !== 6'd2 || load_s !== 6'd59 || mode !== 3'd0) begin
      errors++; $display("FAIL b2b_ok load=%b val=%0d:%0d:%0d mode=%0d exp=1 1:2:59 0", load, load_h, load_m, load_s, mode); end
    btn_ok = 1'b0; btn_inc = 1'b0; step();
  endtask

  task automatic test_reset_mid_edit();
    int base;
    base = load_cnt;
    press_mode(); press_mode();
    tick();
    checks++; if (mode !== 3'd2) begin errors++; $display("FAIL mid_enter mode=%0d exp=2", mode); end
    rst = 1'b1;
    #2;
    checks++; if (mode !== 3'd0 || run_en !== 1'b1 || load !== 1'b0) begin
      errors++; $display("FAIL mid_reset mode=%0d run_en=%b load=%b exp=0/1/0", mode, run_en, load); end
    checks++; if (alarm_h !== 6'd6 || alarm_m !== 6'd0 || alarm_en !== 1'b0) begin
      errors++; $display("FAIL mid_alarm alarm=%0d:%0d en=%b exp=6:0 0", alarm_h, alarm_m, alarm_en); end
    step();
    rst = 1'b0;
    step();
    checks++; if (load_cnt != base || mode !== 3'd0) begin
      errors++; $display("FAIL mid_noload loads=%0d mode=%0d exp=0/0", load_cnt - base, mode); end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_set_commit();
    test_timeout();
    test_alarm_ring();
    test_back_to_back();
    test_reset_mid_edit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
